// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: latches a 16-bit value and time-multiplexes it as four
// hex digits on a common-anode 7-segment display. It applies optional
// leading-zero blanking and an anti-ghosting guard interval, and it produces
// a periodic single-cycle clktick enable for the processor core.
module seven_seg_scanner #(
    parameter int SCAN_MAX = 49999,
    parameter int GUARD    = 2,
    parameter int TICK_MAX = 24999999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        data_we,
    input  logic [3:0]  dp_in,
    input  logic        lz_blank,
    output logic        AN0,
    output logic        AN1,
    output logic        AN2,
    output logic        AN3,
    output logic        CA,
    output logic        CB,
    output logic        CC,
    output logic        CD,
    output logic        CE,
    output logic        CF,
    output logic        CG,
    output logic        CDP,
    output logic        clktick
);

    localparam int PW = (SCAN_MAX > 0) ? $clog2(SCAN_MAX + 1) : 1;
    localparam int TW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam logic [PW-1:0] SCAN_LAST = PW'(SCAN_MAX);
    localparam logic [PW-1:0] GUARD_V   = PW'(GUARD);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_MAX);

    // Hex font, active-high lit segments packed as {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] lit;
        case (nib)
            4'h0:    lit = 7'h3F;
            4'h1:    lit = 7'h06;
            4'h2:    lit = 7'h5B;
            4'h3:    lit = 7'h4F;
            4'h4:    lit = 7'h66;
            4'h5:    lit = 7'h6D;
            4'h6:    lit = 7'h7D;
            4'h7:    lit = 7'h07;
            4'h8:    lit = 7'h7F;
            4'h9:    lit = 7'h6F;
            4'hA:    lit = 7'h77;
            4'hB:    lit = 7'h7C;
            4'hC:    lit = 7'h39;
            4'hD:    lit = 7'h5E;
            4'hE:    lit = 7'h79;
            4'hF:    lit = 7'h71;
            default: lit = 7'h00;
        endcase
        return lit;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    dig_q, dig_d;
    logic [15:0]   val_q, val_d;
    logic [3:0]    dps_q, dps_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          cdp_q, cdp_d;
    logic          clktick_q, clktick_d;

    logic [3:0]    nib_s;
    logic          blank_s;
    logic          in_guard_s;
    logic          dp_bit_s;
    logic          z3_s, z2_s, z1_s;

    // Next-state for counters and shadows, plus next output values from current state
    always_comb begin
        presc_d   = presc_q;
        dig_d     = dig_q;
        val_d     = val_q;
        dps_d     = dps_q;
        tick_d    = tick_q;
        an_d      = 4'hF;
        seg_d     = 7'h7F;
        cdp_d     = 1'b1;
        clktick_d = 1'b0;
        nib_s     = 4'h0;
        dp_bit_s  = 1'b0;
        blank_s   = 1'b0;

        // Prescaler wrap advances the digit index
        if (presc_q == SCAN_LAST) begin
            presc_d = '0;
            dig_d   = dig_q + 2'd1;
        end else begin
            presc_d = presc_q + PW'(1);
            dig_d   = dig_q;
        end

        if (data_we) begin
            val_d = data_in;
            dps_d = dp_in;
        end else begin
            val_d = val_q;
            dps_d = dps_q;
        end

        if (tick_q == TICK_LAST) begin
            tick_d    = '0;
            clktick_d = 1'b1;
        end else begin
            tick_d    = tick_q + TW'(1);
            clktick_d = 1'b0;
        end

        z3_s = (val_q[15:12] == 4'h0);
        z2_s = (val_q[11:8]  == 4'h0);
        z1_s = (val_q[7:4]   == 4'h0);

        case (dig_q)
            2'd0:    begin nib_s = val_q[3:0];   dp_bit_s = dps_q[0]; blank_s = 1'b0; end
            2'd1:    begin nib_s = val_q[7:4];   dp_bit_s = dps_q[1]; blank_s = lz_blank && z3_s && z2_s && z1_s; end
            2'd2:    begin nib_s = val_q[11:8];  dp_bit_s = dps_q[2]; blank_s = lz_blank && z3_s && z2_s; end
            2'd3:    begin nib_s = val_q[15:12]; dp_bit_s = dps_q[3]; blank_s = lz_blank && z3_s; end
            default: begin nib_s = 4'h0;         dp_bit_s = 1'b0;     blank_s = 1'b1; end
        endcase

        in_guard_s = (presc_q < GUARD_V);

        if (!in_guard_s && !blank_s) begin
            case (dig_q)
                2'd0:    an_d = 4'b1110;
                2'd1:    an_d = 4'b1101;
                2'd2:    an_d = 4'b1011;
                2'd3:    an_d = 4'b0111;
                default: an_d = 4'b1111;
            endcase
        end else begin
            an_d = 4'b1111;
        end

        // Segments carry the digit pattern even during the guard interval
        if (blank_s) begin
            seg_d = 7'h7F;
            cdp_d = 1'b1;
        end else begin
            seg_d = ~hex_font(nib_s);
            cdp_d = ~dp_bit_s;
        end
    end

    // State and registered outputs; reset forces the display dark and counters to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            dig_q     <= 2'd0;
            val_q     <= 16'h0000;
            dps_q     <= 4'h0;
            tick_q    <= '0;
            an_q      <= 4'hF;
            seg_q     <= 7'h7F;
            cdp_q     <= 1'b1;
            clktick_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            dig_q     <= dig_d;
            val_q     <= val_d;
            dps_q     <= dps_d;
            tick_q    <= tick_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            cdp_q     <= cdp_d;
            clktick_q <= clktick_d;
        end
    end

    assign AN0     = an_q[0];
    assign AN1     = an_q[1];
    assign AN2     = an_q[2];
    assign AN3     = an_q[3];
    assign CA      = seg_q[0];
    assign CB      = seg_q[1];
    assign CC      = seg_q[2];
    assign CD      = seg_q[3];
    assign CE      = seg_q[4];
    assign CF      = seg_q[5];
    assign CG      = seg_q[6];
    assign CDP     = cdp_q;
    assign clktick = clktick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed testbench for seven_seg_scanner with SCAN_MAX=7, GUARD=2, TICK_MAX=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seven_seg_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic        data_we;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic        AN0, AN1, AN2, AN3;
    logic        CA, CB, CC, CD, CE, CF, CG, CDP;
    logic        clktick;

    int n_pass  = 0;
    int n_total = 0;

    wire [3:0] an_w  = {AN3, AN2, AN1, AN0};
    wire [6:0] seg_w = {CG, CF, CE, CD, CC, CB, CA};

    seven_seg_scanner #(.SCAN_MAX(7), .GUARD(2), .TICK_MAX(4)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_we(data_we),
        .dp_in(dp_in), .lz_blank(lz_blank),
        .AN0(AN0), .AN1(AN1), .AN2(AN2), .AN3(AN3),
        .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG),
        .CDP(CDP), .clktick(clktick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse reset and return on the falling edge where it is released
    task automatic do_reset;
        @(negedge clk);
        rst     = 1'b1;
        data_we = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_total++;
            if ({an_w, seg_w, CDP, clktick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, {an_w, seg_w, CDP, clktick}, 13'b1111111111110);
            end else n_pass++;
        end
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_total++;
            if (an_w !== ((k == 3) ? 4'b1110 : 4'b1111)) begin
                $display("FAIL reset_release edge=%0d an=%b exp=%b", k, an_w, (k == 3) ? 4'b1110 : 4'b1111);
            end else n_pass++;
        end
    endtask

    task automatic test_scan;
        logic [6:0] es [4];
        logic [3:0] ea;
        int p, d;
        es[0] = 7'h19; es[1] = 7'h30; es[2] = 7'h24; es[3] = 7'h79; // "4","3","2","1"
        do_reset();
        lz_blank = 1'b0; dp_in = 4'h0; data_in = 16'h1234; data_we = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            data_we = 1'b0;
            p = (k - 1) % 8;
            d = ((k - 1) / 8) % 4;
            ea = (p >= 2) ? ~(4'b0001 << d) : 4'b1111;
            n_total++;
            if (an_w !== ea) $display("FAIL scan_an edge=%0d an=%b exp=%b", k, an_w, ea);
            else n_pass++;
            if (k >= 2) begin
                n_total++;
                if (seg_w !== es[d]) $display("FAIL scan_seg edge=%0d seg=%h exp=%h", k, seg_w, es[d]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_blanking;
        logic [6:0]  es [4];
        logic [3:0]  bl;
        logic [3:0]  ea;
        logic [6:0]  eseg;
        logic [15:0] v;
        int p, d;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) begin
                v = 16'h000F; bl = 4'b1110;
                es[0] = 7'h0E; es[1] = 7'h7F; es[2] = 7'h7F; es[3] = 7'h7F;
            end else begin
                v = 16'h0A00; bl = 4'b1000;
                es[0] = 7'h40; es[1] = 7'h40; es[2] = 7'h08; es[3] = 7'h7F;
            end
            do_reset();
            lz_blank = 1'b1; dp_in = 4'h0; data_in = v; data_we = 1'b1;
            for (int k = 1; k <= 32; k++) begin
                @(negedge clk);
                data_we = 1'b0;
                p = (k - 1) % 8;
                d = ((k - 1) / 8) % 4;
                ea = (p >= 2 && !bl[d]) ? ~(4'b0001 << d) : 4'b1111;
                eseg = es[d];
                if (k >= 2) begin
                    n_total++;
                    if ({an_w, seg_w, CDP} !== {ea, eseg, 1'b1})
                        $display("FAIL blank v=%h edge=%0d got=%b exp=%b", v, k, {an_w, seg_w, CDP}, {ea, eseg, 1'b1});
                    else n_pass++;
                end
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_dp;
        logic [3:0] ea;
        logic       edp;
        int p, d;
        do_reset();
        lz_blank = 1'b0; dp_in = 4'b0101; data_in = 16'h8888; data_we = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            data_we = 1'b0;
            p = (k - 1) % 8;
            d = ((k - 1) / 8) % 4;
            ea = (p >= 2) ? ~(4'b0001 << d) : 4'b1111;
            edp = (d == 0 || d == 2) ? 1'b0 : 1'b1;
            if (k >= 2) begin
                n_total++;
                if ({an_w, seg_w, CDP} !== {ea, 7'h00, edp})
                    $display("FAIL dp edge=%0d got=%b exp=%b", k, {an_w, seg_w, CDP}, {ea, 7'h00, edp});
                else n_pass++;
            end
        end
        dp_in = 4'h0;
    endtask

    task automatic test_tick;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            n_total++;
            if (clktick !== ((k % 5) == 0)) $display("FAIL tick_free edge=%0d got=%b exp=%b", k, clktick, (k % 5) == 0);
            else n_pass++;
        end
        do_reset();
        repeat (12) @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++;
        if (clktick !== 1'b0) $display("FAIL tick_rst got=%b exp=0", clktick);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_total++;
            if (clktick !== ((k % 5) == 0)) $display("FAIL tick_restart edge=%0d got=%b exp=%b", k, clktick, (k % 5) == 0);
            else n_pass++;
        end
        // clktick is high here; reset must clear it without waiting for a clock
        rst = 1'b1;
        #1;
        n_total++;
        if (clktick !== 1'b0) $display("FAIL tick_async_clear got=%b exp=0", clktick);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_during_scan;
        do_reset();
        lz_blank = 1'b0; dp_in = 4'h0; data_in = 16'h1234; data_we = 1'b1;
        @(negedge clk);
        data_we = 1'b0;
        repeat (11) @(negedge clk);
        // after edge 12: digit 1 active showing "3"; write lands on edge 13
        data_in = 16'hFFFF; data_we = 1'b1;
        @(negedge clk);
        data_we = 1'b0;
        n_total++;
        if ({an_w, seg_w} !== {4'b1101, 7'h30}) $display("FAIL wr_old got=%b exp=%b", {an_w, seg_w}, {4'b1101, 7'h30});
        else n_pass++;
        for (int k = 14; k <= 16; k++) begin
            @(negedge clk);
            n_total++;
            if ({an_w, seg_w} !== {4'b1101, 7'h0E}) $display("FAIL wr_new edge=%0d got=%b exp=%b", k, {an_w, seg_w}, {4'b1101, 7'h0E});
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        lz_blank = 1'b0; dp_in = 4'h0;
        data_in = 16'h1111; data_we = 1'b1;
        @(negedge clk);
        data_in = 16'h2222;
        @(negedge clk);
        data_in = 16'h0003;
        @(negedge clk);
        data_we = 1'b0;
        for (int k = 4; k <= 32; k++) begin
            @(negedge clk);
            if (k <= 8) begin
                n_total++;
                if ({an_w[0], seg_w} !== {(k >= 3) ? 1'b0 : 1'b1, 7'h30})
                    $display("FAIL b2b_d0 edge=%0d got=%b exp=%b", k, {an_w[0], seg_w}, {1'b0, 7'h30});
                else n_pass++;
            end else if (k >= 27) begin
                n_total++;
                if ({an_w, seg_w} !== {4'b0111, 7'h40})
                    $display("FAIL b2b_d3 edge=%0d got=%b exp=%b", k, {an_w, seg_w}, {4'b0111, 7'h40});
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; data_in = 16'h0000; data_we = 1'b0; dp_in = 4'h0; lz_blank = 1'b0;
        test_reset();
        test_scan();
        test_blanking();
        test_dp();
        test_tick();
        test_write_during_scan();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
